// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: mode selection and bounce direction.
package led_seq_pkg;

    // Step modes, as driven on the mode input
    localparam logic [1:0] MODE_ROT_UP = 2'd0;
    localparam logic [1:0] MODE_ROT_DN = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    // Bounce direction, remembered across mode changes
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/led_pwm.sv
// Global PWM dimmer: free-running duty counter compared against brightness.
// All-ones brightness is forced fully on, so the duty scale reaches 100%.
module led_pwm #(
    parameter int DUTY_W = 4
) (
    input  logic              clk24,
    input  logic              rst,
    input  logic [DUTY_W-1:0] brightness,
    output logic              pwm_on
);

    logic [DUTY_W-1:0] pwm_cnt;

    // Free-running duty counter, wraps naturally at 2^DUTY_W
    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
        end
    end

    // On while the counter is below the requested duty, or always at full scale
    always_comb begin
        pwm_on = (&brightness) | (pwm_cnt < brightness);
    end

endmodule

// File: rtl/led_sequencer.sv
// Single-position LED sequencer: one active-low LED lit at a time, stepped by a
// prescaled tick or a manual request in rotate-up, rotate-down, bounce or hold
// mode, dimmed by a global PWM. Outputs are registered for direct pin drive.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LEDS   = 3,
    parameter int TICK_DIV = 8388608,
    parameter int DUTY_W   = 4
) (
    input  logic                                  clk24,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic [1:0]                            mode,
    input  logic                                  step_i,
    input  logic [DUTY_W-1:0]                     brightness,
    output logic [N_LEDS-1:0]                     leds_n,
    output logic                                  step_o,
    output logic [((N_LEDS > 1) ? $clog2(N_LEDS) : 1)-1:0] pos_o
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int POS_W   = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0]   POS_ONE    = POS_W'(1);

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic               adv;

    logic [POS_W-1:0]   pos;
    logic [POS_W-1:0]   pos_next;
    logic               dir;
    logic               dir_next;

    logic [N_LEDS-1:0]  lit;
    logic               pwm_on;

    // Prescaler: counts only while enabled, wraps at TICK_DIV-1
    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (enable) begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
            end else begin
                presc <= presc + PRESC_W'(1);
            end
        end
    end

    // A tick coinciding with a manual request still yields a single step
    always_comb begin
        tick = enable && (presc == PRESC_LAST);
        adv  = tick || step_i;
    end

    // Next position/direction; a single LED never moves, and bounce reverses
    // and moves in the same step so the end positions are never repeated
    always_comb begin
        pos_next = pos;
        dir_next = dir;
        if (adv && (N_LEDS > 1)) begin
            case (mode)
                MODE_ROT_UP: begin
                    pos_next = (pos == POS_LAST) ? '0 : pos + POS_ONE;
                end
                MODE_ROT_DN: begin
                    pos_next = (pos == '0) ? POS_LAST : pos - POS_ONE;
                end
                MODE_BOUNCE: begin
                    if ((dir == DIR_UP) && (pos == POS_LAST)) begin
                        dir_next = DIR_DN;
                        pos_next = pos - POS_ONE;
                    end else if ((dir == DIR_DN) && (pos == '0)) begin
                        dir_next = DIR_UP;
                        pos_next = pos + POS_ONE;
                    end else if (dir == DIR_UP) begin
                        pos_next = pos + POS_ONE;
                    end else begin
                        pos_next = pos - POS_ONE;
                    end
                end
                default: begin
                    pos_next = pos;
                end
            endcase
        end
    end

    // One-hot decode of the upcoming position
    always_comb begin
        lit = '0;
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            lit[i] = (pos_next == POS_W'(i));
        end
    end

    // Position state, step strobe and LED drive all update on the same edge
    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            pos    <= '0;
            dir    <= DIR_UP;
            step_o <= 1'b0;
            leds_n <= '1;
        end else begin
            pos    <= pos_next;
            dir    <= dir_next;
            step_o <= adv && (pos_next != pos);
            leds_n <= ~(lit & {N_LEDS{pwm_on}});
        end
    end

    assign pos_o = pos;

    led_pwm #(
        .DUTY_W(DUTY_W)
    ) u_pwm (
        .clk24      (clk24),
        .rst        (rst),
        .brightness (brightness),
        .pwm_on     (pwm_on)
    );

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: three builds (3, 4 and 1 LEDs) share stimulus.
module tb_led_sequencer;
    import led_seq_pkg::*;

    logic       clk24 = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = MODE_ROT_UP;
    logic       step_i = 1'b0;
    logic [3:0] brightness = 4'd15;

    logic [2:0] leds3;
    logic       step3;
    logic [1:0] pos3;
    logic [3:0] leds4;
    logic       step4;
    logic [1:0] pos4;
    logic [0:0] leds1;
    logic       step1;
    logic [0:0] pos1;

    int checks = 0;
    int errors = 0;

    always #5 clk24 = ~clk24;

    led_sequencer #(.N_LEDS(3), .TICK_DIV(4), .DUTY_W(4)) dut3 (
        .clk24(clk24), .rst(rst), .enable(enable), .mode(mode), .step_i(step_i),
        .brightness(brightness), .leds_n(leds3), .step_o(step3), .pos_o(pos3));

    led_sequencer #(.N_LEDS(4), .TICK_DIV(4), .DUTY_W(4)) dut4 (
        .clk24(clk24), .rst(rst), .enable(enable), .mode(mode), .step_i(step_i),
        .brightness(brightness), .leds_n(leds4), .step_o(step4), .pos_o(pos4));

    led_sequencer #(.N_LEDS(1), .TICK_DIV(4), .DUTY_W(4)) dut1 (
        .clk24(clk24), .rst(rst), .enable(enable), .mode(mode), .step_i(step_i),
        .brightness(brightness), .leds_n(leds1), .step_o(step1), .pos_o(pos1));

    // Reset pulse ending on a falling edge; the next rising edge is cycle 1
    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk24);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        brightness = 4'd15; mode = MODE_ROT_UP; enable = 1'b1; step_i = 1'b0;
        rst = 1'b1;
        #2;
        checks++;
        if (leds3 !== 3'b111 || pos3 !== 2'd0 || step3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_n3: leds=%b pos=%0d step=%b, want 111/0/0", leds3, pos3, step3);
        end
        checks++;
        if (leds4 !== 4'b1111 || pos4 !== 2'd0 || step4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_n4: leds=%b pos=%0d step=%b, want 1111/0/0", leds4, pos4, step4);
        end
        checks++;
        if (leds1 !== 1'b1 || pos1 !== 1'b0 || step1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_n1: leds=%b pos=%0d step=%b, want 1/0/0", leds1, pos1, step1);
        end
        @(negedge clk24);
        rst = 1'b0;
    endtask

    task automatic test_rotate_up();
        logic [1:0] ep;
        logic [2:0] el;
        logic       es;
        brightness = 4'd15; mode = MODE_ROT_UP; enable = 1'b1; step_i = 1'b0;
        apply_reset();
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk24);
            ep = 2'((c / 4) % 3);
            el = ~(3'b001 << ep);
            es = (c % 4 == 0);
            checks++;
            if (pos3 !== ep || leds3 !== el || step3 !== es) begin
                errors++;
                $display("FAIL rot_up c%0d: pos=%0d leds=%b step=%b, want %0d/%b/%b",
                         c, pos3, leds3, step3, ep, el, es);
            end
        end
    endtask

    task automatic test_bounce();
        int         bseq [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
        logic [1:0] ep;
        logic [3:0] el;
        logic       es;
        brightness = 4'd15; mode = MODE_BOUNCE; enable = 1'b1; step_i = 1'b0;
        apply_reset();
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk24);
            ep = 2'(bseq[c / 4]);
            el = ~(4'b0001 << ep);
            es = (c % 4 == 0);
            checks++;
            if (pos4 !== ep || leds4 !== el || step4 !== es) begin
                errors++;
                $display("FAIL bounce c%0d: pos=%0d leds=%b step=%b, want %0d/%b/%b",
                         c, pos4, leds4, step4, ep, el, es);
            end
        end
    endtask

    task automatic test_manual_step();
        int hold_seq [3] = '{2, 0, 1};
        brightness = 4'd15; mode = MODE_ROT_UP; enable = 1'b0; step_i = 1'b0;
        apply_reset();
        step_i = 1'b1;
        @(negedge clk24);
        step_i = 1'b0;
        checks++;
        if (pos3 !== 2'd1 || step3 !== 1'b1 || leds3 !== 3'b101) begin
            errors++;
            $display("FAIL single_step: pos=%0d step=%b leds=%b, want 1/1/101", pos3, step3, leds3);
        end
        repeat (6) @(negedge clk24);
        checks++;
        if (pos3 !== 2'd1 || step3 !== 1'b0) begin
            errors++;
            $display("FAIL frozen: pos=%0d step=%b, want 1/0", pos3, step3);
        end
        step_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk24);
            checks++;
            if (pos3 !== 2'(hold_seq[i]) || step3 !== 1'b1) begin
                errors++;
                $display("FAIL held_step %0d: pos=%0d step=%b, want %0d/1", i, pos3, step3, hold_seq[i]);
            end
        end
        step_i = 1'b0;
        @(negedge clk24);
        checks++;
        if (pos3 !== 2'd1 || step3 !== 1'b0) begin
            errors++;
            $display("FAIL held_release: pos=%0d step=%b, want 1/0", pos3, step3);
        end
        // prescaler still at 0: three enabled cycles bring it to the tick value
        enable = 1'b1;
        repeat (3) @(negedge clk24);
        checks++;
        if (pos3 !== 2'd1) begin
            errors++;
            $display("FAIL pre_tick: pos=%0d, want 1", pos3);
        end
        step_i = 1'b1;
        @(negedge clk24);
        step_i = 1'b0;
        enable = 1'b0;
        checks++;
        if (pos3 !== 2'd2 || step3 !== 1'b1) begin
            errors++;
            $display("FAIL tick_and_step: pos=%0d step=%b, want 2/1", pos3, step3);
        end
        repeat (3) @(negedge clk24);
        checks++;
        if (pos3 !== 2'd2 || step3 !== 1'b0) begin
            errors++;
            $display("FAIL after_coincide: pos=%0d step=%b, want 2/0", pos3, step3);
        end
    endtask

    task automatic test_pwm();
        int duties [3] = '{4, 14, 15};
        int lows;
        mode = MODE_HOLD; enable = 1'b0; step_i = 1'b0; brightness = 4'd0;
        apply_reset();
        for (int c = 0; c < 32; c++) begin
            @(negedge clk24);
            checks++;
            if (leds3 !== 3'b111) begin
                errors++;
                $display("FAIL pwm_off c%0d: leds=%b, want 111", c, leds3);
            end
        end
        for (int d = 0; d < 3; d++) begin
            brightness = 4'(duties[d]);
            lows = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk24);
                if (leds3 === 3'b110) lows++;
                checks++;
                if (leds3 !== 3'b110 && leds3 !== 3'b111) begin
                    errors++;
                    $display("FAIL pwm_shape b%0d c%0d: leds=%b, want 110 or 111", duties[d], c, leds3);
                end
            end
            checks++;
            if (lows !== ((duties[d] == 15) ? 16 : duties[d])) begin
                errors++;
                $display("FAIL pwm_duty b%0d: lit %0d of 16 cycles, want %0d",
                         duties[d], lows, (duties[d] == 15) ? 16 : duties[d]);
            end
        end
    endtask

    task automatic test_hold_then_down();
        logic [1:0] ep;
        logic       es;
        brightness = 4'd15; mode = MODE_HOLD; enable = 1'b1; step_i = 1'b0;
        apply_reset();
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk24);
            checks++;
            if (pos3 !== 2'd0 || step3 !== 1'b0) begin
                errors++;
                $display("FAIL hold c%0d: pos=%0d step=%b, want 0/0", c, pos3, step3);
            end
        end
        mode = MODE_ROT_DN;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk24);
            ep = (c < 4) ? 2'd0 : ((c < 8) ? 2'd2 : 2'd1);
            es = (c == 4 || c == 8);
            checks++;
            if (pos3 !== ep || step3 !== es) begin
                errors++;
                $display("FAIL rot_dn c%0d: pos=%0d step=%b, want %0d/%b", c, pos3, step3, ep, es);
            end
        end
    endtask

    task automatic test_reset_mid_bounce();
        int         bseq [3] = '{0, 1, 2};
        logic [1:0] ep;
        brightness = 4'd15; mode = MODE_BOUNCE; enable = 1'b1; step_i = 1'b0;
        apply_reset();
        repeat (16) @(negedge clk24);
        checks++;
        if (pos4 !== 2'd2) begin
            errors++;
            $display("FAIL bounce_setup: pos=%0d, want 2", pos4);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (leds4 !== 4'b1111 || pos4 !== 2'd0 || step4 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: leds=%b pos=%0d step=%b, want 1111/0/0", leds4, pos4, step4);
        end
        @(negedge clk24);
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk24);
            ep = 2'(bseq[c / 4]);
            checks++;
            if (pos4 !== ep || step4 !== (c % 4 == 0)) begin
                errors++;
                $display("FAIL post_reset c%0d: pos=%0d step=%b, want %0d/%b",
                         c, pos4, step4, ep, (c % 4 == 0));
            end
        end
    endtask

    task automatic test_single_led();
        brightness = 4'd15; mode = MODE_ROT_UP; enable = 1'b1; step_i = 1'b0;
        apply_reset();
        for (int c = 1; c <= 16; c++) begin
            mode = 2'(c % 4);
            step_i = c[0];
            @(negedge clk24);
            checks++;
            if (pos1 !== 1'b0 || step1 !== 1'b0 || leds1 !== 1'b0) begin
                errors++;
                $display("FAIL single_led c%0d: pos=%0d step=%b leds=%b, want 0/0/0",
                         c, pos1, step1, leds1);
            end
        end
        step_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rotate_up();
        test_bounce();
        test_manual_step();
        test_pwm();
        test_hold_then_down();
        test_reset_mid_bounce();
        test_single_led();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
